// File: rtl/pipelined_tightly_coupled_negator.sv
// Fixed-latency two's-complement negator: negation in front of stage 0, then a
// plain valid/data register chain of PIPELINE_DEPTH stages with no stall path.
module pipelined_tightly_coupled_negator #(
    parameter int PIPELINE_DEPTH = 1,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  input_valid,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data
);

    // Valid/data protocol: no handshake. input_valid=1 marks an operand in the
    // cycle it is high; output_valid=1 marks a result, and output_data is 0
    // whenever output_valid is 0.
    logic [PIPELINE_DEPTH-1:0]                 valid_q;
    logic [PIPELINE_DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0]                     neg_d;

    // Idle cycles load zero so empty stages never carry stale data.
    assign neg_d = input_valid ? (~input_data + DATA_WIDTH'(1)) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= input_valid;
            data_q[0]  <= neg_d;
            for (int i = 1; i < PIPELINE_DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign output_valid = valid_q[PIPELINE_DEPTH-1];
    assign output_data  = data_q[PIPELINE_DEPTH-1];

endmodule

// File: tb/tb_pipelined_tightly_coupled_negator.sv
// Directed bench for the negator: a depth-1/32-bit instance and a depth-4/16-bit instance.
module tb_pipelined_tightly_coupled_negator;

  logic        clock;
  logic        reset;
  logic        in_valid_a;
  logic [31:0] in_data_a;
  logic        out_valid_a;
  logic [31:0] out_data_a;
  logic        in_valid_b;
  logic [15:0] in_data_b;
  logic        out_valid_b;
  logic [15:0] out_data_b;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  pipelined_tightly_coupled_negator #(.PIPELINE_DEPTH(1), .DATA_WIDTH(32)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (in_valid_a),
    .input_data   (in_data_a),
    .output_valid (out_valid_a),
    .output_data  (out_data_a)
  );

  pipelined_tightly_coupled_negator #(.PIPELINE_DEPTH(4), .DATA_WIDTH(16)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (in_valid_b),
    .input_data   (in_data_b),
    .output_valid (out_valid_b),
    .output_data  (out_data_b)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic v, input logic [31:0] d);
    in_valid_a = v;
    in_data_a  = d;
  endtask

  task automatic drive_b(input logic v, input logic [15:0] d);
    in_valid_b = v;
    in_data_b  = d;
  endtask

  // Depth-1 vectors: {valid, data, expected valid, expected data}, result one cycle later.
  localparam int NV = 12;
  logic        vec_v  [NV] = '{1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
  logic [31:0] vec_d  [NV] = '{32'h5, 32'hDEAD, 32'h1, 32'h2, 32'hFFFFFFFF, 32'h0,
                               32'h80000000, 32'h7, 32'hABCD, 32'h9, 32'h1234, 32'h0};
  logic [31:0] vec_ed [NV] = '{32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'h0,
                               32'h80000000, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF7, 32'h0, 32'h0};

  initial begin
    logic [15:0] x;
    logic [15:0] e;
    reset = 1'b1;
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    #1 reset = 1'b0;
    #1;
    check("rst_valid_a", out_valid_a, 0);
    check("rst_data_a",  out_data_a,  0);
    check("rst_valid_b", out_valid_b, 0);
    check("rst_data_b",  out_data_b,  0);
    repeat (2) @(negedge clock);
    check("rst_hold_valid_a", out_valid_a, 0);
    reset = 1'b1;

    // depth 1: single, back-to-back, boundaries, bubbles
    for (int i = 0; i < NV; i++) begin
      drive_a(vec_v[i], vec_d[i]);
      @(negedge clock);
      check($sformatf("vec%0d_valid", i), out_valid_a, vec_v[i]);
      check($sformatf("vec%0d_data", i),  out_data_a,  vec_ed[i]);
    end
    drive_a(1'b0, '0);

    // depth 4: single operand latency
    drive_b(1'b1, 16'h0003);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      drive_b(1'b0, 16'h5555);
      check($sformatf("deep_lat%0d_valid", c), out_valid_b, (c == 4));
      check($sformatf("deep_lat%0d_data", c),  out_data_b,  (c == 4) ? 16'hFFFD : 16'h0);
    end

    // depth 4: random stream against a reference model
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        x = 16'($urandom_range(0, 16'hFFFF));
        e = 16'h0 - x;
        exp_q.push_back(e);
        drive_b(1'b1, x);
      end else begin
        drive_b(1'b0, 16'($urandom_range(0, 16'hFFFF)));
      end
      @(negedge clock);
      check($sformatf("stream%0d_valid", c), out_valid_b, (c >= 3 && c <= 12));
      if (out_valid_b && exp_q.size() > 0)
        check($sformatf("stream%0d_data", c), out_data_b, exp_q.pop_front());
    end
    check("stream_drained", exp_q.size(), 0);
    drive_b(1'b0, '0);

    // asynchronous reset mid-flight
    drive_a(1'b1, 32'h11);
    drive_b(1'b1, 16'h0022);
    @(negedge clock);
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    check("pre_rst_valid_a", out_valid_a, 1);
    check("pre_rst_data_a",  out_data_a,  32'hFFFFFFEF);
    #2 reset = 1'b0;
    #1;
    check("async_valid_a", out_valid_a, 0);
    check("async_data_a",  out_data_a,  0);
    check("async_valid_b", out_valid_b, 0);
    check("async_data_b",  out_data_b,  0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      check($sformatf("post_rst%0d_valid_b", c), out_valid_b, 0);
      check($sformatf("post_rst%0d_data_b", c),  out_data_b,  0);
      check($sformatf("post_rst%0d_valid_a", c), out_valid_a, 0);
    end

    // first operand after release is accepted normally
    drive_a(1'b1, 32'h80000001);
    @(negedge clock);
    drive_a(1'b0, '0);
    check("post_rst_op_valid_a", out_valid_a, 1);
    check("post_rst_op_data_a",  out_data_a,  32'h7FFFFFFF);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
